// File: rtl/debounce_pkg.sv
// Shared FSM encodings for the pushbutton debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'b00,
    S_WAIT_HIGH = 2'b01,
    S_HIGH      = 2'b10,
    S_WAIT_LOW  = 2'b11
  } state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running prescaler: one-cycle tick every SAMPLE_DIV clocks.
module sample_tick_gen #(
  parameter int SAMPLE_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = $clog2(SAMPLE_DIV);
  localparam logic [W-1:0] LAST = W'(SAMPLE_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/debounce_pulse.sv
// Pushbutton debouncer with press pulse and optional release pulse.
// Release pulse enabled by defining DEBOUNCE_RELEASE_PULSE_EN.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int STABLE_CNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic en_out,
  output logic rel_out,
  output logic busy
);

  localparam int CW = cnt_width(STABLE_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic sync_q1;
  logic sync;
  logic tick;

  state_t state;
  state_t nstate;
  logic [CW-1:0] stable_cnt;
  logic [CW-1:0] ncnt;
  logic [CW-1:0] cnt_inc;
  logic en_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q1 <= 1'b0;
      sync    <= 1'b0;
    end else begin
      sync_q1 <= btn_in;
      sync    <= sync_q1;
    end
  end

  sample_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign cnt_inc = (stable_cnt == CNT_MAX) ? stable_cnt
                                           : stable_cnt + CNT_ONE;

  always_comb begin
    nstate = state;
    ncnt   = stable_cnt;
    if (tick) begin
      unique case (state)
        S_LOW: begin
          if (sync) begin
            ncnt   = CNT_ONE;
            nstate = (CNT_ONE == CNT_MAX) ? S_HIGH : S_WAIT_HIGH;
          end
        end
        S_WAIT_HIGH: begin
          if (sync) begin
            ncnt = cnt_inc;
            if (cnt_inc == CNT_MAX) nstate = S_HIGH;
          end else begin
            ncnt   = '0;
            nstate = S_LOW;
          end
        end
        S_HIGH: begin
          if (!sync) begin
            ncnt   = CNT_ONE;
            nstate = (CNT_ONE == CNT_MAX) ? S_LOW : S_WAIT_LOW;
          end
        end
        S_WAIT_LOW: begin
          if (!sync) begin
            ncnt = cnt_inc;
            if (cnt_inc == CNT_MAX) nstate = S_LOW;
          end else begin
            ncnt   = '0;
            nstate = S_HIGH;
          end
        end
        default: begin
          ncnt   = '0;
          nstate = S_LOW;
        end
      endcase
    end
  end

  // Pulses fire only on entry from the low/high side, never on bounce-back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LOW;
      stable_cnt <= '0;
      en_q       <= 1'b0;
    end else begin
      state      <= nstate;
      stable_cnt <= ncnt;
      en_q       <= !state[1] && (nstate == S_HIGH);
    end
  end

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic rel_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rel_q <= 1'b0;
    end else begin
      rel_q <= state[1] && (nstate == S_LOW);
    end
  end

  assign rel_out = rel_q;
`else
  assign rel_out = 1'b0;
`endif

  assign level  = state[1];
  assign busy   = state[0];
  assign en_out = en_q;

endmodule

// File: tb/tb_debounce_pulse.sv
// Self-checking bench for debounce_pulse: vector table, corner sequences, random.
module tb_debounce_pulse;

  localparam int DIV = 4;
  localparam int N   = 3;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_in = 1'b0;
  logic level;
  logic en_out;
  logic rel_out;
  logic busy;

  always #5 clk = ~clk;

  debounce_pulse #(
    .SAMPLE_DIV(DIV),
    .STABLE_CNT(N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_in (btn_in),
    .level  (level),
    .en_out (en_out),
    .rel_out(rel_out),
    .busy   (busy)
  );

  int errors = 0;
  int checks = 0;
  int en_cnt = 0;
  int rel_cnt = 0;

  // Reference: accepted level plus length of the current run of
  // samples disagreeing with it; a run of N flips the level.
  bit m_lvl;
  int m_run;
  int m_cyc;
  bit m_q[$];
  bit m_en;
  bit m_rel;

  function automatic void model_reset();
    m_lvl = 1'b0;
    m_run = 0;
    m_cyc = 0;
    m_q = {};
    m_q.push_back(1'b0);
    m_q.push_back(1'b0);
    m_en = 1'b0;
    m_rel = 1'b0;
  endfunction

  function automatic void model_step(input bit b);
    bit s;
    s = m_q.pop_front();
    m_q.push_back(b);
    m_en = 1'b0;
    m_rel = 1'b0;
    if (m_cyc % DIV == DIV - 1) begin
      if (s != m_lvl) begin
        m_run++;
        if (m_run >= N) begin
          m_lvl = s;
          m_run = 0;
          if (s) m_en = 1'b1;
          else m_rel = REL_EN;
        end
      end else begin
        m_run = 0;
      end
    end
    m_cyc++;
  endfunction

  task automatic check_vec(input string name, input logic [3:0] act,
                           input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lvl/busy/en/rel=%b want %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit b);
    btn_in = b;
    @(posedge clk);
    #1;
    if (rst) model_step(b);
    check_vec("cycle", {level, busy, en_out, rel_out},
              {m_lvl, m_run > 0, m_en, m_rel});
    if (en_out) en_cnt++;
    if (rel_out) rel_cnt++;
  endtask

  typedef struct {
    bit btn;
    int cycles;
    int en;
    int rel;
    bit lvl;
  } seg_t;

  seg_t tbl[7];

  initial begin
    int first;
    int waited;
    bit b;
    int len;

    tbl[0] = '{btn: 1'b0, cycles: 20,   en: 0, rel: 0,      lvl: 1'b0};
    tbl[1] = '{btn: 1'b1, cycles: 40,   en: 1, rel: 0,      lvl: 1'b1};
    tbl[2] = '{btn: 1'b0, cycles: 40,   en: 0, rel: REL_EN, lvl: 1'b0};
    tbl[3] = '{btn: 1'b1, cycles: 5,    en: 0, rel: 0,      lvl: 1'b0};
    tbl[4] = '{btn: 1'b0, cycles: 30,   en: 0, rel: 0,      lvl: 1'b0};
    tbl[5] = '{btn: 1'b1, cycles: 1000, en: 1, rel: 0,      lvl: 1'b1};
    tbl[6] = '{btn: 1'b0, cycles: 40,   en: 0, rel: REL_EN, lvl: 1'b0};

    model_reset();
    rst = 1'b0;
    repeat (3) step(1'b0);
    check_int("reset_cnt", int'(dut.stable_cnt), 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      en_cnt = 0;
      rel_cnt = 0;
      repeat (tbl[i].cycles) step(tbl[i].btn);
      check_int($sformatf("seg%0d_en", i), en_cnt, tbl[i].en);
      check_int($sformatf("seg%0d_rel", i), rel_cnt, tbl[i].rel);
      check_int($sformatf("seg%0d_lvl", i), int'(level), int'(tbl[i].lvl));
      if (i == 5) check_int("sat_cnt", int'(dut.stable_cnt), N);
    end

    en_cnt = 0;
    for (int i = 0; i < 20; i++) step(((i / 3) % 2) == 0);
    check_int("bounce_en", en_cnt, 0);
    check_int("bounce_lvl", int'(level), 0);
    en_cnt = 0;
    repeat (40) step(1'b1);
    check_int("bounce_after_en", en_cnt, 1);
    check_int("bounce_after_lvl", int'(level), 1);
    repeat (40) step(1'b0);

    waited = 0;
    while (m_run != 2 && waited < 40) begin
      step(1'b1);
      waited++;
    end
    check_int("midq_reached", int'(m_run == 2), 1);
    check_int("midq_cnt", int'(dut.stable_cnt), 2);
    #2;
    rst = 1'b0;
    #1;
    check_vec("async_rst", {level, busy, en_out, rel_out}, 4'b0000);
    model_reset();
    repeat (3) step(1'b1);
    rst = 1'b1;
    en_cnt = 0;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1);
      if (en_out && first < 0) first = i;
    end
    check_int("rst_latency", first, 11);
    check_int("rst_en_cnt", en_cnt, 1);
    repeat (40) step(1'b0);

    for (int k = 0; k < 300; k++) begin
      b = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 24);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b0;
        #1;
        check_vec("rand_rst", {level, busy, en_out, rel_out}, 4'b0000);
        model_reset();
        step(b);
        step(b);
        rst = 1'b1;
      end
      repeat (len) step(b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 The module SHALL have parameter SAMPLE_DIV, default 100000, clk cycles per sample tick (>=2).
REQ-002 The module SHALL have parameter STABLE_CNT, default 4, consecutive agreeing samples needed to accept a level change (>=1).
REQ-003 The module SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 The module SHALL have port btn_in  input  1  raw asynchronous pushbutton level.
REQ-006 The module SHALL have port level  output  1  debounced button level.
REQ-007 The module SHALL have port en_out  output  1  one-cycle press pulse, drives a downstream counter's en.
REQ-008 The module SHALL have port rel_out  output  1  one-cycle release pulse (see Configuration).
REQ-009 The module SHALL have port busy  output  1  high while a candidate change is being qualified.

Function
REQ-010 The module SHALL pass btn_in through a 2-flop synchronizer; only the synchronized value (sync) is used downstream.
REQ-011 The module SHALL generate sample_tick: one-cycle pulse every SAMPLE_DIV clk cycles, first at cycle SAMPLE_DIV-1 after reset release; free-running, wraps to 0.
REQ-012 The FSM SHALL have states LOW, WAIT_HIGH, HIGH, WAIT_LOW; all transitions and the stable counter advance only on cycles with sample_tick=1.
REQ-013 In LOW with sync=1 the FSM SHALL go to WAIT_HIGH with stable counter set to 1; with sync=0 it SHALL stay.
REQ-014 In WAIT_HIGH with sync=1 the counter SHALL increment; on reaching STABLE_CNT the FSM SHALL go to HIGH; with sync=0 it SHALL return to LOW and clear the counter.
REQ-015 HIGH and WAIT_LOW SHALL mirror REQ-013/REQ-014 with sync polarity inverted, ending in LOW.
REQ-016 If STABLE_CNT=1, LOW->HIGH and HIGH->LOW SHALL occur directly on the first disagreeing sample.
REQ-017 level SHALL be 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH; busy SHALL be 1 in WAIT_HIGH and WAIT_LOW.
REQ-018 en_out SHALL be registered, high exactly one clk cycle, the cycle after the sample tick causing entry to HIGH; never two pulses per press.
REQ-019 Stable counter width SHALL be $clog2(STABLE_CNT+1); it SHALL saturate, never wrap.
REQ-020 Press-to-en_out latency SHALL be 2 sync cycles plus at most STABLE_CNT sample periods plus 1 cycle.

Reset
REQ-021 On rst=0, regardless of clk, the module SHALL force state LOW, stable counter 0, prescaler 0, synchronizer 0, level=0, en_out=0, rel_out=0, busy=0.
REQ-022 Reset asserted mid-qualification SHALL abandon the candidate with no pulse emitted; after release, btn_in held high SHALL requalify from scratch.

Configuration
REQ-023 With macro DEBOUNCE_RELEASE_PULSE_EN defined, rel_out SHALL pulse one cycle the cycle after the sample tick causing entry to LOW from WAIT_LOW.
REQ-024 Without DEBOUNCE_RELEASE_PULSE_EN, rel_out SHALL be constant 0 and no release-pulse register SHALL be synthesized; port list unchanged.

Structure
REQ-025 FSM state encodings (2-bit LOW=00, WAIT_HIGH=01, HIGH=10, WAIT_LOW=11) SHALL live in shared package debounce_pkg.
REQ-026 The prescaler SHALL be sub-module sample_tick_gen (params SAMPLE_DIV; ports clk, rst, tick); synchronizer and FSM stay in debounce_pulse.

Verification (SAMPLE_DIV=4, STABLE_CNT=3)
REQ-027 Clean press: btn_in 0->1 held 40 cycles -> exactly one en_out pulse, level=1 after 3 consecutive high samples, busy high in between.
REQ-028 Bounce: btn_in toggles every 3 cycles for 20 cycles then holds 1 -> no en_out during bounce, one en_out after 3 stable samples.
REQ-029 Glitch: btn_in high for 5 cycles only -> state returns LOW, en_out never asserted, level stays 0.
REQ-030 Reset mid-op: rst=0 asserted in WAIT_HIGH with count=2 -> outputs 0 immediately (async); after release with btn_in=1, en_out only after 3 fresh samples.
REQ-031 Release with macro: press then release held 40 cycles -> one en_out, then one rel_out, level back to 0; without macro rel_out stays 0 throughout.
REQ-032 Long hold: btn_in=1 for 1000 cycles -> exactly one en_out, level stays 1, stable counter saturated at 3.
